alt_vipvfr131_vfr_packet_generator: RTL and testbench

- Upstream neighbour of the common stream output stage in the frame reader.
- On a per-frame `go`, emits one Avalon-ST Video control packet (type 0xF) carrying width, height and interlace.
- Then emits one image packet (type 0x0) whose payload is width×height pixels passed through from the pixel fetch FIFO.
- Its dout_* port bundle connects directly to the stream output stage's internal int_* port bundle.

---
 rtl/alt_vipvfr131_vfr_packet_generator.sv | 178 +++++++++++++++++
 tb/tb_alt_vipvfr131_vfr_packet_generator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipvfr131_vfr_packet_generator.sv
// Frame packet generator: emits an Avalon-ST Video control packet followed by
// an image packet whose payload is passed straight through from the pixel FIFO.
module alt_vipvfr131_vfr_packet_generator #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [15:0]           width,
  input  logic [15:0]           height,
  input  logic [3:0]            interlace,
  output logic                  busy,
  output logic                  done,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CTRL_HDR  = 3'd1,
    CTRL_DATA = 3'd2,
    IMG_HDR   = 3'd3,
    IMG_DATA  = 3'd4
  } state_t;

  state_t      state_r;
  logic [15:0] width_r;
  logic [15:0] height_r;
  logic [3:0]  interlace_r;
  logic [3:0]  nib_r;
  logic [15:0] col_r;
  logic [15:0] row_r;
  logic        busy_r;
  logic        done_r;

  logic        xfer_s;
  logic        zero_frame_s;
  logic        last_col_s;
  logic        last_pix_s;

  // Control packet payload: width, height MSB nibble first, then interlace.
  function automatic logic [3:0] ctrl_nibble(input logic [3:0] k, input logic [15:0] w,
                                             input logic [15:0] h, input logic [3:0] il);
    case (k)
      4'd0:    ctrl_nibble = w[15:12];
      4'd1:    ctrl_nibble = w[11:8];
      4'd2:    ctrl_nibble = w[7:4];
      4'd3:    ctrl_nibble = w[3:0];
      4'd4:    ctrl_nibble = h[15:12];
      4'd5:    ctrl_nibble = h[11:8];
      4'd6:    ctrl_nibble = h[7:4];
      4'd7:    ctrl_nibble = h[3:0];
      default: ctrl_nibble = il;
    endcase
  endfunction

  assign xfer_s       = dout_valid & dout_ready;
  assign zero_frame_s = (width_r == 16'd0) || (height_r == 16'd0);
  assign last_col_s   = (col_r == width_r - 16'd1);
  assign last_pix_s   = last_col_s && (row_r == height_r - 16'd1);
  assign busy         = busy_r;
  assign done         = done_r;

  // Beat generation: headers come from registered state, pixels pass through.
  always_comb begin
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_sop   = 1'b0;
    dout_eop   = 1'b0;
    pix_ready  = 1'b0;
    case (state_r)
      CTRL_HDR: begin
        dout_valid     = 1'b1;
        dout_sop       = 1'b1;
        dout_data[3:0] = 4'hF;
      end
      CTRL_DATA: begin
        dout_valid     = 1'b1;
        dout_data[3:0] = ctrl_nibble(nib_r, width_r, height_r, interlace_r);
        dout_eop       = (nib_r == 4'd8);
      end
      IMG_HDR: begin
        dout_valid = 1'b1;
        dout_sop   = 1'b1;
        dout_eop   = zero_frame_s;
      end
      IMG_DATA: begin
        dout_valid = pix_valid;
        dout_data  = pix_data;
        pix_ready  = dout_ready;
        dout_eop   = last_pix_s;
      end
      default: begin
        dout_valid = 1'b0;
      end
    endcase
  end

  // Frame sequencing, parameter latching and pixel position tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      width_r     <= 16'd0;
      height_r    <= 16'd0;
      interlace_r <= 4'd0;
      nib_r       <= 4'd0;
      col_r       <= 16'd0;
      row_r       <= 16'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go) begin
            width_r     <= width;
            height_r    <= height;
            interlace_r <= interlace;
            busy_r      <= 1'b1;
            state_r     <= CTRL_HDR;
          end
        end
        CTRL_HDR: begin
          if (xfer_s) begin
            nib_r   <= 4'd0;
            state_r <= CTRL_DATA;
          end
        end
        CTRL_DATA: begin
          if (xfer_s) begin
            if (nib_r == 4'd8) begin
              state_r <= IMG_HDR;
            end else begin
              nib_r <= nib_r + 4'd1;
            end
          end
        end
        IMG_HDR: begin
          if (xfer_s) begin
            col_r <= 16'd0;
            row_r <= 16'd0;
            if (zero_frame_s) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= IMG_DATA;
            end
          end
        end
        IMG_DATA: begin
          if (xfer_s) begin
            if (last_pix_s) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else if (last_col_s) begin
              col_r <= 16'd0;
              row_r <= row_r + 16'd1;
            end else begin
              col_r <= col_r + 16'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alt_vipvfr131_vfr_packet_generator.sv
// Self-checking bench: builds each frame's expected beat list from width/height/
// interlace and checks the DUT stream against it every cycle.
module tb_alt_vipvfr131_vfr_packet_generator;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [15:0]   width;
  logic [15:0]   height;
  logic [3:0]    interlace;
  logic          busy;
  logic          done;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          dout_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic          dout_sop;
  logic          dout_eop;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          pix;
  } beat_t;

  beat_t q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    di;
  int    nx;

  alt_vipvfr131_vfr_packet_generator #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .go(go), .width(width), .height(height),
    .interlace(interlace), .busy(busy), .done(done), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .dout_ready(dout_ready),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_sop(dout_sop),
    .dout_eop(dout_eop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Expected stream of one frame; npix limits the enumerated pixels.
  task automatic build_model(input logic [15:0] w, input logic [15:0] h,
                             input logic [3:0] il, input int npix);
    beat_t b;
    int total;
    q.delete();
    b = '{data: DW'(15), sop: 1'b1, eop: 1'b0, pix: 1'b0};
    q.push_back(b);
    for (int k = 0; k < 9; k++) begin
      if (k < 4)      b.data = DW'((w >> (12 - 4 * k)) & 16'hF);
      else if (k < 8) b.data = DW'((h >> (28 - 4 * k)) & 16'hF);
      else            b.data = DW'(il);
      b.sop = 1'b0;
      b.eop = (k == 8);
      q.push_back(b);
    end
    total = int'(w) * int'(h);
    b = '{data: '0, sop: 1'b1, eop: (total == 0), pix: 1'b0};
    q.push_back(b);
    for (int i = 0; i < total && i < npix; i++) begin
      b = '{data: DW'(i), sop: 1'b0, eop: (i == total - 1), pix: 1'b1};
      q.push_back(b);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_sop"}, 32'(dout_sop), 32'd0);
    chk({tag, "_eop"}, 32'(dout_eop), 32'd0);
    chk({tag, "_data"}, 32'(dout_data), 32'd0);
    chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
  endtask

  // Runs one frame cycle by cycle; abort_after>=0 stops once that many beats moved.
  task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                           input bit tog, input int stall_at, input int stall_len,
                           input int abort_after, input bit go_mid,
                           output int done_iter, output int nxfer);
    int pix_idx = 0;
    int stall_cnt = 0;
    bit fin = 1'b0;
    bit moved;
    beat_t f;
    build_model(w, h, il, (abort_after < 0) ? 1 << 20 : abort_after);
    done_iter = -1;
    nxfer = 0;
    for (int it = 0; it < 600 && !fin; it++) begin
      @(negedge clk);
      go        = (it == 0) || (go_mid && it == 5);
      width     = (go_mid && it == 5) ? 16'd1 : w;
      height    = (go_mid && it == 5) ? 16'd1 : h;
      interlace = (go_mid && it == 5) ? 4'd0 : il;
      dout_ready = tog ? (it % 2 == 1) : 1'b1;
      if (stall_len > 0 && pix_idx == stall_at && stall_cnt < stall_len) begin
        pix_valid = 1'b0;
        stall_cnt++;
      end else begin
        pix_valid = 1'b1;
      end
      pix_data = DW'(pix_idx);
      #2;
      if (it == 0) begin
        chk("pre_go_valid", 32'(dout_valid), 32'd0);
        chk("pre_go_busy", 32'(busy), 32'd0);
      end else if (q.size() > 0) begin
        f = q[0];
        chk("busy_in_frame", 32'(busy), 32'd1);
        chk("done_in_frame", 32'(done), 32'd0);
        chk("dout_valid", 32'(dout_valid), f.pix ? 32'(pix_valid) : 32'd1);
        chk("pix_ready", 32'(pix_ready), f.pix ? 32'(dout_ready) : 32'd0);
        if (!f.pix || pix_valid) begin
          chk("dout_data", 32'(dout_data), 32'(f.data));
          chk("dout_sop", 32'(dout_sop), 32'(f.sop));
          chk("dout_eop", 32'(dout_eop), 32'(f.eop));
        end
        moved = dout_ready && (!f.pix || pix_valid);
        if (moved) begin
          void'(q.pop_front());
          nxfer++;
          if (f.pix) pix_idx++;
          if (abort_after >= 0 && nxfer == abort_after) fin = 1'b1;
        end
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("valid_at_done", 32'(dout_valid), 32'd0);
        done_iter = it;
        fin = 1'b1;
      end
    end
    go = 1'b0;
    if (!fin) chk("frame_timeout", 32'd1, 32'd0);
    if (abort_after < 0 && fin) begin
      @(negedge clk);
      #2;
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_idle_zero(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp1 [19];
    logic [DW-1:0] exp5 [8];
    exp1 = '{10'hF, 10'h0, 10'h0, 10'h0, 10'h4, 10'h0, 10'h0, 10'h0, 10'h2, 10'h3,
             10'h0, 10'h0, 10'h1, 10'h2, 10'h3, 10'h4, 10'h5, 10'h6, 10'h7};
    exp5 = '{10'h1, 10'h2, 10'h3, 10'h4, 10'h0, 10'hA, 10'hB, 10'hC};
    rst = 1'b1; go = 1'b0; width = 16'd0; height = 16'd0; interlace = 4'd0;
    pix_valid = 1'b0; pix_data = '0; dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Pin the model against hand-computed beat lists.
    build_model(16'd4, 16'd2, 4'h3, 1 << 20);
    chk("model_len", 32'(q.size()), 32'd19);
    for (int i = 0; i < 19; i++) chk("model_data", 32'(q[i].data), 32'(exp1[i]));
    chk("model_sop_ctrl", 32'(q[0].sop), 32'd1);
    chk("model_sop_img", 32'(q[10].sop), 32'd1);
    chk("model_eop_ctrl", 32'(q[9].eop), 32'd1);
    chk("model_eop_img", 32'(q[18].eop), 32'd1);
    build_model(16'h1234, 16'h0ABC, 4'h6, 0);
    for (int i = 0; i < 8; i++) chk("model_nib_1234", 32'(q[i + 1].data), 32'(exp5[i]));

    run_frame(16'd4, 16'd2, 4'h3, 1'b0, 0, 0, -1, 1'b0, di, nx);
    chk("f1_done_cycle", 32'(di), 32'd20);
    chk("f1_transfers", 32'(nx), 32'd19);

    run_frame(16'd4, 16'd2, 4'h3, 1'b1, 0, 0, -1, 1'b0, di, nx);
    chk("f2_transfers", 32'(nx), 32'd19);

    run_frame(16'd4, 16'd2, 4'h3, 1'b0, 2, 5, -1, 1'b0, di, nx);
    chk("f3_done_cycle", 32'(di), 32'd25);

    run_frame(16'd0, 16'd5, 4'h9, 1'b0, 0, 0, -1, 1'b0, di, nx);
    chk("f4_done_cycle", 32'(di), 32'd12);

    run_frame(16'h1234, 16'h0ABC, 4'h6, 1'b0, 0, 0, 11, 1'b1, di, nx);
    chk("f5_transfers", 32'(nx), 32'd11);
    do_reset("f5_abort");

    run_frame(16'd4, 16'd2, 4'h3, 1'b0, 0, 0, 16, 1'b0, di, nx);
    chk("f6_transfers", 32'(nx), 32'd16);
    do_reset("f6_abort");

    run_frame(16'd2, 16'd1, 4'h0, 1'b0, 0, 0, -1, 1'b0, di, nx);
    chk("f7_done_cycle", 32'(di), 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
